audio_interp_upsampler: RTL
===========================

# audio_interp_upsampler

Upsampling front end of the audio DAC path. Accepts signed PCM samples at the audio rate over a valid/ready handshake and holds or linearly interpolates them up to the modulator clock rate, 2^OSR_LOG2 output cycles per input sample. It converts the result to the offset-binary (unsigned) word consumed every clock by the downstream delta-sigma modulator's `data_i`.

## Interface
- `BITWIDTH`, 16: sample width, both input and output.
- `OSR_LOG2`, 5: log2 of the oversampling ratio; N = 2^OSR_LOG2 output cycles per sample, legal range 1..8.
- `clk_i` input 1: modulator clock; all logic on the rising edge.
- `n_rst_i` input 1: reset, asynchronous, active-low.
- `data_i` input BITWIDTH: input sample, signed two's complement.
- `valid_i` input 1: `data_i` is valid.
- `ready_o` output 1: the block can accept a sample.
- `data_o` output BITWIDTH: registered offset-binary sample to the modulator.
- `underflow_o` output 1: one-cycle pulse when a frame starts with no new sample available.

## Operation
- Registers:
  - phase counter `cnt` (OSR_LOG2 bits, free-running 0..N-1);
  - one-entry input buffer `buf` with flag `full`;
  - start point `a` and end point `b` (signed BITWIDTH);
  - accumulator `acc` (signed BITWIDTH+OSR_LOG2+1).
- `ready_o = !full`, combinational from the register.
- Handshake:
  - `valid_i && ready_o` on an edge loads `buf <= data_i` and sets `full <= 1`.
  - `valid_i` while `ready_o` is low is ignored; no data is lost or stored.
- Frame boundary: the edge where `cnt == N-1`.
  - `cnt <= 0`, `a <= b`, `acc <= b <<< OSR_LOG2`.
  - If `full`: `b <= buf` and `full <= 0`.
  - Otherwise: `b` is unchanged (the last sample repeats) and `underflow_o` pulses high for the next cycle.
- Every other edge: `cnt <= cnt+1`, `acc <= acc + (b - a)`, where `b - a` is computed at BITWIDTH+1 bits and sign-extended.
- Interpolated value: `y = acc >>> OSR_LOG2`, an arithmetic shift, i.e. floor.
  - At phase j, y = a + floor((b-a)·j/N).
  - y always lies between a and b, so it never overflows BITWIDTH.
- Output: `data_o <= {~y[BITWIDTH-1], y[BITWIDTH-2:0]}`, which is the signed-to-offset-binary conversion (MSB inverted).
- Boundary cases:
  - A handshake on the boundary edge while `full == 0`: the sample is stored in `buf` but not consumed at that boundary. That boundary still counts as an underflow, and the sample is consumed at the next boundary.
  - A handshake is impossible on the boundary edge while `full == 1`, because `ready_o` is low.
  - Full-scale step from -2^(BITWIDTH-1) to 2^(BITWIDTH-1)-1: `b - a` must not wrap, hence the BITWIDTH+1-bit difference.
  - `cnt` wraps naturally at N-1 → 0.
- Reset (asynchronous, at any time including mid-frame): all state returns to its reset value; an accepted but unconsumed `buf` is discarded.

## Timing
- Reset values:
  - `cnt = 0`, `a = b = 0`, `acc = 0`, `full = 0`, `buf = 0`;
  - `ready_o = 1`, `underflow_o = 0`;
  - `data_o = 2^(BITWIDTH-1)` (mid-scale, 0x8000 at 16 bits).
- `data_o` lags `acc` by one cycle: the value for phase j appears in the cycle after phase j.
- A sample accepted during frame k becomes `b` in frame k+1. It is first reached exactly at phase 0 of frame k+2, when it becomes `a`.
- Without the macro, it is visible on `data_o` one cycle after the frame k→k+1 boundary.
- Maximum sustained input rate: one sample per N cycles. `ready_o` falls for at least the cycle after acceptance and remains low until the next boundary.

## Configuration
- `AUDIO_INTERP_LINEAR_EN` defined: linear interpolation as specified above.
- Not defined: zero-order hold.
  - `acc`, `a` and the difference adder are removed.
  - `data_o <= offset-binary(b)` every cycle.
  - Handshake, buffer, `cnt`, boundary and underflow behaviour are identical.

## Test plan
All scenarios use BITWIDTH=16, OSR_LOG2=2 (N=4), macro defined unless stated.
- Reset asserted mid-frame with `full=1` -> `data_o=0x8000`, `ready_o=1`, `underflow_o=0` immediately, without waiting for a clock edge; the buffered sample never appears on `data_o`.
- Push 0x0400 right after reset, then no further samples -> across frames `data_o` is 0x8000 ×4, then 0x8000, 0x8100, 0x8200, 0x8300, then 0x8400 held.
- Same stimulus continued -> `underflow_o` pulses once at every subsequent boundary.
- Push 0x7FFF then 0x8000 back to back -> the ramp descends monotonically from 0xFFFF toward 0x0000 with no wrap; the step is −0x4000 per cycle, with floor applied to negative values.
- Hold `valid_i` high with incrementing data -> exactly one sample is accepted per 4 cycles; `ready_o` is low from acceptance until the boundary, and `underflow_o` never pulses.
- Handshake exactly on the boundary edge with an empty buffer -> `underflow_o` pulses; the sample is consumed at the following boundary.
- Macro undefined, push 0x0400 then 0xFC00 -> `data_o` steps to 0x8400 for 4 cycles, then 0x7C00; no intermediate values.

Source files
------------

// File: rtl/audio_interp_upsampler_if.sv
// Sample handshake and modulator-side bus of the audio upsampler.
//   data_i      : signed PCM sample from the audio-rate source
//   valid_i     : data_i is valid
//   ready_o     : upsampler can accept a sample
//   data_o      : offset-binary word to the delta-sigma modulator, every clock
//   underflow_o : one-cycle pulse when a frame starts without a new sample
// The master modport is the source/observer side; the slave modport is the
// upsampler itself.
interface audio_interp_upsampler_if #(
  parameter int unsigned BITWIDTH = 16
);
  logic [BITWIDTH-1:0] data_i;
  logic                valid_i;
  logic                ready_o;
  logic [BITWIDTH-1:0] data_o;
  logic                underflow_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o,
    input  data_o,
    input  underflow_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o,
    output data_o,
    output underflow_o
  );
endinterface

// File: rtl/audio_interp_upsampler.sv
// Upsampling front end of the audio DAC path.
// Accepts signed PCM samples at the audio rate and produces one offset-binary
// word per modulator clock, 2^OSR_LOG2 output cycles per input sample.
//
// Build option:
//   AUDIO_INTERP_LINEAR_EN defined   : linear interpolation between samples.
//   AUDIO_INTERP_LINEAR_EN undefined : zero-order hold of the current sample.
//
// Parameters:
//   BITWIDTH : sample width, input and output (default 16)
//   OSR_LOG2 : log2 of the oversampling ratio, legal range 1..8 (default 5)
//
// Ports:
//   clk_i   : modulator clock, rising edge
//   n_rst_i : asynchronous active-low reset
//   bus     : slave side of audio_interp_upsampler_if
//             (data_i/valid_i/ready_o handshake, data_o, underflow_o)
module audio_interp_upsampler #(
  parameter int unsigned BITWIDTH = 16,
  parameter int unsigned OSR_LOG2 = 5
) (
  input  logic                      clk_i,
  input  logic                      n_rst_i,
  audio_interp_upsampler_if.slave   bus
);

  // Accumulator holds a*N + j*(b-a): sample width, OSR_LOG2 fraction, one guard bit.
  localparam int unsigned AW = BITWIDTH + OSR_LOG2 + 1;
  // Endpoint difference needs one extra bit so a full-scale step cannot wrap.
  localparam int unsigned DW = BITWIDTH + 1;

  logic [OSR_LOG2-1:0]        cnt;
  logic                       full;
  logic [BITWIDTH-1:0]        sample_buf;
  logic signed [BITWIDTH-1:0] b_q;
  logic                       underflow_q;
  logic [BITWIDTH-1:0]        data_q;

  logic                       boundary_c;
  logic                       accept_c;
  logic signed [BITWIDTH-1:0] y_c;

  // Last phase of the frame; the next edge starts a new frame.
  assign boundary_c = &cnt;
  assign accept_c   = bus.valid_i && !full;

  assign bus.ready_o     = !full;
  assign bus.underflow_o = underflow_q;
  assign bus.data_o      = data_q;

  // Phase counter, one-entry input buffer, end point and underflow flag.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      cnt         <= '0;
      full        <= 1'b0;
      sample_buf  <= '0;
      b_q         <= '0;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= boundary_c && !full;

      if (boundary_c) begin
        cnt <= '0;
        if (full) begin
          b_q <= $signed(sample_buf);
        end
      end else begin
        cnt <= cnt + OSR_LOG2'(1);
      end

      if (accept_c) begin
        sample_buf <= bus.data_i;
      end

      // A sample accepted on an underflowing boundary stays buffered until
      // the following boundary; ready_o keeps a second one out meanwhile.
      if (boundary_c && full) begin
        full <= 1'b0;
      end else if (accept_c) begin
        full <= 1'b1;
      end
    end
  end

`ifdef AUDIO_INTERP_LINEAR_EN
  logic signed [BITWIDTH-1:0] a_q;
  logic signed [AW-1:0]       acc_q;
  logic signed [DW-1:0]       diff_c;
  logic signed [AW-1:0]       acc_shr_c;
  logic                       unused_acc_hi_c;

  assign diff_c = {b_q[BITWIDTH-1], b_q} - {a_q[BITWIDTH-1], a_q};

  // Start point and accumulator; at a boundary the old end point becomes
  // the new start point and the accumulator restarts at a*N.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      a_q   <= '0;
      acc_q <= '0;
    end else if (boundary_c) begin
      a_q   <= b_q;
      acc_q <= {b_q[BITWIDTH-1], b_q, {OSR_LOG2{1'b0}}};
    end else begin
      acc_q <= acc_q + {{OSR_LOG2{diff_c[DW-1]}}, diff_c};
    end
  end

  // Arithmetic shift floors toward -inf; the result lies between a and b,
  // so the upper bits are pure sign extension.
  assign acc_shr_c       = acc_q >>> OSR_LOG2;
  assign y_c             = acc_shr_c[BITWIDTH-1:0];
  assign unused_acc_hi_c = ^acc_shr_c[AW-1:BITWIDTH];
`else
  assign y_c = b_q;
`endif

  // Signed to offset-binary: invert the MSB; reset to mid-scale.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      data_q <= {1'b1, {(BITWIDTH-1){1'b0}}};
    end else begin
      data_q <= {~y_c[BITWIDTH-1], y_c[BITWIDTH-2:0]};
    end
  end

endmodule
